// File: rtl/mem_access_stage.sv
// Memory stage of the 5-stage RV32I pipeline: data-memory req/ack access, store lane
// formatting, load extraction, and the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  regWrite_m,
    input  logic [1:0]            resultSrc_m,
    input  logic                  memWrite_m,
    input  logic                  MemRead_m,
    input  logic [2:0]            MemCtrl_m,
    input  logic [DATA_WIDTH-1:0] aluResult_m,
    input  logic [DATA_WIDTH-1:0] writeData_m,
    input  logic [4:0]            destinationReg_m,
    input  logic [DATA_WIDTH-1:0] pcPlus4_m,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  stall_m,
    output logic                  regWrite_w,
    output logic [1:0]            resultSrc_w,
    output logic [DATA_WIDTH-1:0] aluResult_w,
    output logic [DATA_WIDTH-1:0] readData_w,
    output logic [4:0]            destinationReg_w,
    output logic [DATA_WIDTH-1:0] pcPlus4_w,
    output logic                  misalign_w
);

    // state  | meaning
    // S_IDLE | no access outstanding; a good access issues dmem_req this cycle
    // S_WAIT | access issued, waiting for dmem_ack with upstream stalled
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t state_q, state_d;

    logic                  access, bad, good, is_load;
    logic [1:0]            off;
    logic [DATA_WIDTH-1:0] sh, load_data;

    logic                  regWrite_q, regWrite_d;
    logic [1:0]            resultSrc_q, resultSrc_d;
    logic [DATA_WIDTH-1:0] aluResult_q, aluResult_d;
    logic [DATA_WIDTH-1:0] readData_q, readData_d;
    logic [4:0]            destReg_q, destReg_d;
    logic [DATA_WIDTH-1:0] pcPlus4_q, pcPlus4_d;
    logic                  misalign_q, misalign_d;

    assign access  = MemRead_m | memWrite_m;
    assign off     = aluResult_m[1:0];
    assign is_load = MemRead_m & ~memWrite_m;

    always_comb begin
        bad = 1'b0;
        if (access) begin
            case (MemCtrl_m)
                3'b000, 3'b100: bad = 1'b0;
                3'b001, 3'b101: bad = off[0];
                3'b010:         bad = (off != 2'b00);
                default:        bad = 1'b1;
            endcase
        end
    end

    assign good = access & ~bad;

    // Upstream is frozen while in S_WAIT, so the address/data derived from *_m stay stable.
    assign dmem_req  = ~rst & (good | (state_q == S_WAIT));
    assign stall_m   = dmem_req & ~dmem_ack;
    assign dmem_we   = good & memWrite_m;
    assign dmem_addr = {aluResult_m[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = writeData_m;
        case (MemCtrl_m[1:0])
            2'b00: begin
                dmem_wdata = {4{writeData_m[7:0]}};
                dmem_be    = 4'b0001 << off;
            end
            2'b01: begin
                dmem_wdata = {2{writeData_m[15:0]}};
                dmem_be    = 4'b0011 << off;
            end
            default: dmem_be = 4'b1111;
        endcase
        if (!dmem_we) dmem_be = 4'b0000;
    end

    assign sh = dmem_rdata >> {off, 3'b000};

    always_comb begin
        case (MemCtrl_m)
            3'b000:  load_data = {{24{sh[7]}}, sh[7:0]};
            3'b100:  load_data = {24'h0, sh[7:0]};
            3'b001:  load_data = {{16{sh[15]}}, sh[15:0]};
            3'b101:  load_data = {16'h0, sh[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d     = (dmem_req && !dmem_ack) ? S_WAIT : S_IDLE;
        regWrite_d  = 1'b0;
        misalign_d  = 1'b0;
        resultSrc_d = resultSrc_q;
        aluResult_d = aluResult_q;
        readData_d  = readData_q;
        destReg_d   = destReg_q;
        pcPlus4_d   = pcPlus4_q;
        if (!stall_m) begin
            regWrite_d  = regWrite_m & ~bad;
            misalign_d  = bad;
            resultSrc_d = resultSrc_m;
            aluResult_d = aluResult_m;
            readData_d  = (good && is_load) ? load_data : '0;
            destReg_d   = destinationReg_m;
            pcPlus4_d   = pcPlus4_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            regWrite_q  <= 1'b0;
            resultSrc_q <= '0;
            aluResult_q <= '0;
            readData_q  <= '0;
            destReg_q   <= '0;
            pcPlus4_q   <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            regWrite_q  <= regWrite_d;
            resultSrc_q <= resultSrc_d;
            aluResult_q <= aluResult_d;
            readData_q  <= readData_d;
            destReg_q   <= destReg_d;
            pcPlus4_q   <= pcPlus4_d;
            misalign_q  <= misalign_d;
        end
    end

    assign regWrite_w       = regWrite_q;
    assign resultSrc_w      = resultSrc_q;
    assign aluResult_w      = aluResult_q;
    assign readData_w       = readData_q;
    assign destinationReg_w = destReg_q;
    assign pcPlus4_w        = pcPlus4_q;
    assign misalign_w       = misalign_q;

endmodule
